// File: rtl/uart_pkg.sv
// uart_pkg: encodings shared by the UART transmit and receive paths.
//   - TX frame state encoding (3-bit, legacy-compatible constants)
//   - Parity type selector values
//   - Serial line levels for idle, start and stop bits
package uart_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    localparam logic LINE_IDLE = 1'b1;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/uart_tx_shifter.sv
// uart_tx_shifter: LSB-out shift register with a bit counter.
//   clk       : bit clock
//   rst       : synchronous active-high reset (clears register and counter)
//   load      : capture load_data, counter to 0
//   shift_en  : shift right by one, advance counter (wraps after last bit)
//   load_data : parallel word to serialize
//   bit0      : current LSB of the register
//   bit1      : next bit to become the LSB (lookahead for a registered line)
//   last      : counter is at the final bit index
module uart_tx_shifter #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic                  shift_en,
    input  logic [DATA_WIDTH-1:0] load_data,
    output logic                  bit0,
    output logic                  bit1,
    output logic                  last
);

    localparam int unsigned CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;

    assign bit0 = shift_q[0];
    assign bit1 = shift_q[1];
    assign last = (cnt_q == CNT_W'(DATA_WIDTH - 1));

    always_comb begin
        shift_d = shift_q;
        cnt_d   = cnt_q;
        if (load) begin
            shift_d = load_data;
            cnt_d   = '0;
        end else if (shift_en) begin
            shift_d = {1'b0, shift_q[DATA_WIDTH-1:1]};
            cnt_d   = last ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx_frame_serializer.sv
// uart_tx_frame_serializer: UART transmit framer, one bit per CLK.
//   CLK        : TX bit clock
//   RST        : synchronous active-high reset, aborts any frame
//   P_DATA     : byte to send, sampled only when idle with Data_Valid
//   Data_Valid : transmit request strobe
//   PAR_EN     : append a parity bit to this frame
//   PAR_TYP    : 0 even, 1 odd parity
//   TX_OUT     : registered serial line (idles high)
//   Busy       : registered, high for every cycle of a frame
// Frame: start, DATA_WIDTH data bits LSB first, optional parity, stop.
module uart_tx_frame_serializer
    import uart_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  Data_Valid,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic                  TX_OUT,
    output logic                  Busy
);

    logic [2:0] state_q, state_d;
    logic       tx_q, tx_d;
    logic       busy_q, busy_d;
    logic       par_en_q, par_en_d;
    logic       par_bit_q, par_bit_d;

    logic       sh_load, sh_shift, sh_bit0, sh_bit1, sh_last;

    uart_tx_shifter #(.DATA_WIDTH(DATA_WIDTH)) u_shifter (
        .clk       (CLK),
        .rst       (RST),
        .load      (sh_load),
        .shift_en  (sh_shift),
        .load_data (P_DATA),
        .bit0      (sh_bit0),
        .bit1      (sh_bit1),
        .last      (sh_last)
    );

    // The line and Busy are registered, so each transition computes the
    // level belonging to the state being entered. While in DATA the line
    // already shows bit0, so the lookahead bit1 is what goes out next.
    always_comb begin
        state_d   = state_q;
        tx_d      = tx_q;
        par_en_d  = par_en_q;
        par_bit_d = par_bit_q;
        sh_load   = 1'b0;
        sh_shift  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                tx_d = LINE_IDLE;
                if (Data_Valid) begin
                    sh_load   = 1'b1;
                    par_en_d  = PAR_EN;
                    par_bit_d = (PAR_TYP == PAR_ODD) ? ~(^P_DATA) : ^P_DATA;
                    state_d   = ST_START;
                    tx_d      = START_BIT;
                end
            end
            ST_START: begin
                state_d = ST_DATA;
                tx_d    = sh_bit0;
            end
            ST_DATA: begin
                sh_shift = 1'b1;
                if (sh_last) begin
                    state_d = par_en_q ? ST_PARITY : ST_STOP;
                    tx_d    = par_en_q ? par_bit_q : STOP_BIT;
                end else begin
                    tx_d    = sh_bit1;
                end
            end
            ST_PARITY: begin
                state_d = ST_STOP;
                tx_d    = STOP_BIT;
            end
            ST_STOP: begin
                state_d = ST_IDLE;
                tx_d    = LINE_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                tx_d    = LINE_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= ST_IDLE;
            tx_q      <= LINE_IDLE;
            busy_q    <= 1'b0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
            par_en_q  <= par_en_d;
            par_bit_q <= par_bit_d;
        end
    end

    assign TX_OUT = tx_q;
    assign Busy   = busy_q;

endmodule
